// File: rtl/nios2_oci_dct_capture_ctrl.sv
// Debug-trace capture sequencer: packs 3-bit trace fragments into 30-bit words,
// hands full words to a trace-memory writer, and flushes the partial word on test end.
module nios2_oci_dct_capture_ctrl #(
  parameter int FRAG_W         = 3,
  parameter int FRAGS_PER_WORD = 10,
  parameter int CNT_W          = 4,
  parameter int DROP_W         = 8,
  localparam int WORD_W        = FRAG_W * FRAGS_PER_WORD
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              arm_i,
  input  logic              frag_valid_i,
  input  logic [FRAG_W-1:0] frag_data_i,
  input  logic              test_ending_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [CNT_W-1:0]  word_count_o,
  output logic [WORD_W-1:0] dct_buffer_o,
  output logic [CNT_W-1:0]  dct_count_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic              test_has_ended_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_ENDED} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wvalid_q, wvalid_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    wcount_q, wcount_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                ended_q, ended_d;

  logic out_free;
  logic buf_full;
  logic accept;
  logic move;
  logic arming;

  assign out_free = !wvalid_q || word_ready_i;
  assign buf_full = (cnt_q == CNT_W'(FRAGS_PER_WORD));
  assign accept   = (state_q == S_CAPTURE) && frag_valid_i;
  assign arming   = ((state_q == S_IDLE) || (state_q == S_ENDED)) && arm_i;
  // A full word moves during capture; during flush any non-empty buffer moves.
  assign move     = out_free && (((state_q == S_CAPTURE) && buf_full) ||
                                 ((state_q == S_FLUSH) && (cnt_q != '0)));

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm_i)         state_d = S_CAPTURE;
      S_CAPTURE: if (test_ending_i) state_d = S_FLUSH;
      S_FLUSH:   if ((cnt_q == '0) && out_free) state_d = S_ENDED;
      S_ENDED:   if (arm_i)         state_d = S_CAPTURE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;
    wcount_d = wcount_q;
    drop_d   = drop_q;
    ended_d  = ended_q;

    if (move) begin
      wdata_d  = buf_q;
      wcount_d = cnt_q;
      wvalid_d = 1'b1;
      buf_d    = '0;
      cnt_d    = '0;
    end else if (wvalid_q && word_ready_i) begin
      wvalid_d = 1'b0;
    end

    // After a move the freed buffer takes the same-cycle fragment in slot 0.
    if (accept) begin
      if (move || !buf_full) begin
        buf_d[cnt_d*FRAG_W +: FRAG_W] = frag_data_i;
        cnt_d = cnt_d + 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end

    if (arming) begin
      buf_d = '0;
      cnt_d = '0;
      if (state_q == S_ENDED) begin
        ended_d = 1'b0;
        drop_d  = '0;
      end
    end

    if ((state_q == S_FLUSH) && (state_d == S_ENDED)) ended_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wcount_q <= '0;
      drop_q   <= '0;
      ended_q  <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wcount_q <= wcount_d;
      drop_q   <= drop_d;
      ended_q  <= ended_d;
    end
  end

  always_comb begin
    busy_o           = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
    word_valid_o     = wvalid_q;
    word_data_o      = wdata_q;
    word_count_o     = wcount_q;
    dct_buffer_o     = buf_q;
    dct_count_o      = cnt_q;
    drop_count_o     = drop_q;
    test_has_ended_o = ended_q;
  end

endmodule

// File: doc/nios2_oci_dct_capture_ctrl.md
Name: nios2_oci_dct_capture_ctrl

Overview:
Debug-trace capture sequencer for the OCI debug path. It packs 3-bit trace fragments from a non-stallable trace source into a 30-bit capture buffer, exposed as dct_buffer and dct_count. It hands each completed word to a trace-memory writer over a valid/ready handshake. On test end it flushes any partial word and then raises test_has_ended, which is the signal pair consumed by the OCI test bench.

Parameters:
FRAG_W, 3, bits per trace fragment
FRAGS_PER_WORD, 10, fragments packed per buffer word (buffer width = FRAG_W*FRAGS_PER_WORD = 30)
CNT_W, 4, width of fragment counters (must hold FRAGS_PER_WORD)
DROP_W, 8, width of saturating drop counter

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
arm  in  1  start or restart capture (sampled in IDLE and ENDED only)
frag_valid  in  1  trace fragment present this cycle; no back-pressure to source
frag_data  in  3  trace fragment
test_ending  in  1  request to stop capture and flush (level or pulse; sampled in CAPTURE)
word_valid  out  1  output word register holds a word
word_ready  in  1  writer accepts the word this cycle
word_data  out  30  packed word
word_count  out  4  valid fragments in word_data (1..10)
dct_buffer  out  30  live capture buffer
dct_count  out  4  fragments currently in dct_buffer (0..10)
drop_count  out  8  fragments lost to overflow, saturating
test_has_ended  out  1  capture finished and fully drained (sticky)
busy  out  1  state is CAPTURE or FLUSH

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation discards buffer and output word with no partial emission.
- States and transitions:
  - IDLE: arm=1 -> CAPTURE, clearing dct_buffer and dct_count.
  - CAPTURE: test_ending=1 -> FLUSH at next edge.
  - FLUSH -> ENDED when dct_count==0 and the output register is free.
  - ENDED: arm=1 -> CAPTURE, clearing test_has_ended, drop_count, dct_buffer and dct_count.
- Fragments are accepted only in CAPTURE. A fragment that arrives in the same cycle as test_ending is still accepted. Fragments in IDLE, FLUSH or ENDED are ignored and are not counted as drops.
- Packing: fragment k of a word goes to dct_buffer[3k+2:3k], LSB first. dct_count increments by 1 per accepted fragment.
- "Output register free" this cycle means word_valid==0, or word_valid&&word_ready.
- Word move (dct_count==10 and output register free):
  - word_data<=dct_buffer, word_count<=10, word_valid<=1.
  - The buffer clears in the same edge.
  - A fragment arriving in the same cycle goes to slot 0, so dct_count=1. This gives zero-bubble throughput.
- Overflow (dct_count==10 and output register not free):
  - An arriving fragment is dropped.
  - drop_count increments and saturates at 255.
  - The buffer is unchanged.
- Handshake:
  - word_valid stays high and word_data/word_count stay stable until word_ready.
  - On transfer with no new move, word_valid<=0 next edge.
  - A transfer and a new move in the same cycle keep word_valid=1 with the new word.
- FLUSH:
  - If dct_count>0 and the output register is free: move the partial word with word_count=dct_count; unused upper buffer bits are 0.
  - Then wait for that word to be accepted before entering ENDED.
- ENDED: test_has_ended=1 (registered, asserted the edge ENDED is entered); word_valid=0.
- Latency:
  - Fragment to dct_buffer/dct_count: 1 edge.
  - 10th fragment to word_valid: 2 edges, or more while the output register is blocked.
  - test_ending to test_has_ended with nothing pending: 2 edges.

Test Plan:
- Fill a word: arm, 10 fragments of 3'b101, word_ready=1 -> word_valid for 1 cycle with word_data=30'h2DB6DB6D, word_count=10; dct_count returns to 0; drop_count=0.
- Partial flush: 4 fragments of 3'b111, then test_ending -> one word with word_data=30'h00000FFF, word_count=4; test_has_ended=1 the edge after word_ready; busy=0.
- Overflow: word_ready=0, 25 consecutive fragments -> word 1 held in the output register, dct_count=10, drop_count=5. Then release word_ready -> word 1 transfers, word 2 moves, dct_count=0.
- Back-to-back: word_ready=1, 30 consecutive fragments with value k mod 8 -> 3 words, no drops, no idle cycle between accepted fragments; word_data checked per slot.
- Empty end: arm, no fragments, test_ending -> no word_valid; test_has_ended=1 two edges later. Then arm -> test_has_ended=0, drop_count=0, busy=1.
- Reset mid-operation: dct_count=6 and word_valid=1, assert reset for 1 cycle -> all outputs 0, state IDLE. Fragments are ignored until arm.
